// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART receive and transmit paths.
//   uart_rx_state_t : receiver FSM state encoding
//   calc_cpb        : clock cycles per bit for a given clock and line rate
//   DATA_BITS       : data bits per frame (8N1)
//   STOP_BITS       : stop bits per frame
package uart_pkg;

  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_HIGH = 3'd4
  } uart_rx_state_t;

  // Integer clock cycles per bit; the fractional part is absorbed by the
  // mid-bit sampling margin.
  function automatic int calc_cpb(input int unsigned frequency,
                                  input int unsigned baud_rate);
    return int'(frequency / baud_rate);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock show-ahead FIFO.
//   clk, rst_n  : clock and asynchronous active-low reset (empties the FIFO)
//   wr_en       : write request; accepted when not full, or when full and a
//                 read is accepted in the same cycle
//   wr_data     : data to write
//   rd_en       : read request; ignored while empty
//   rd_data     : head entry, forced to zero while empty
//   full, empty : occupancy flags
module sync_fifo #(
  parameter int width = 8,
  parameter int depth = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [width-1:0] wr_data,
  input  logic             rd_en,
  output logic [width-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(depth);

  // One extra pointer bit distinguishes full from empty when the
  // address bits are equal.
  logic [AW:0]      wr_ptr_r;
  logic [AW:0]      rd_ptr_r;
  logic [width-1:0] mem_r [depth];
  logic             empty_s;
  logic             full_s;
  logic             do_rd_s;
  logic             do_wr_s;

  assign empty_s = (wr_ptr_r == rd_ptr_r);
  assign full_s  = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                   (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign do_rd_s = rd_en && !empty_s;
  // A simultaneous read frees the slot, so a full FIFO still takes the write.
  assign do_wr_s = wr_en && (!full_s || do_rd_s);

  assign full    = full_s;
  assign empty   = empty_s;
  assign rd_data = empty_s ? {width{1'b0}} : mem_r[rd_ptr_r[AW-1:0]];

  // Pointer update; pointers wrap naturally at 2*depth.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {(AW+1){1'b0}};
      rd_ptr_r <= {(AW+1){1'b0}};
    end else begin
      if (do_wr_s) begin
        wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
      end
      if (do_rd_s) begin
        rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
      end
    end
  end

  // Storage write; contents are don't-care while empty because the head is masked.
  always_ff @(posedge clk) begin
    if (do_wr_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= wr_data;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with a show-ahead receive FIFO.
//   clk, rst_n   : system clock, asynchronous active-low reset
//   uart_rxp     : serial input, asynchronous, idles high
//   rx_data      : byte at the FIFO head (0x00 while empty)
//   rx_valid     : FIFO not empty
//   rx_ready     : consumer takes rx_data this cycle
//   frame_err    : one-cycle pulse when a stop bit is sampled low
//   overrun_err  : one-cycle pulse when a good byte is dropped on a full FIFO
//   rx_busy      : FSM is not idle
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned frequency  = 27_000_000,
  parameter int unsigned baud_rate  = 115_200,
  parameter int          fifo_depth = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       uart_rxp,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun_err,
  output logic       rx_busy
);

  localparam int CPB  = calc_cpb(frequency, baud_rate);
  localparam int HALF = CPB / 2;
  localparam int TW   = $clog2(CPB);

  localparam logic [TW-1:0] CPB_M1    = TW'(CPB - 1);
  localparam logic [TW-1:0] HALF_M1   = TW'(HALF - 1);
  localparam logic [2:0]    LAST_BIT  = 3'(DATA_BITS - 1);

  logic                 sync1_r;
  logic                 rxs_r;
  uart_rx_state_t       state_r;
  uart_rx_state_t       state_s;
  logic [TW-1:0]        timer_r;
  logic [TW-1:0]        timer_s;
  logic [2:0]           bit_idx_r;
  logic [2:0]           bit_idx_s;
  logic [7:0]           shift_r;
  logic [7:0]           shift_s;
  logic                 push_s;
  logic                 ferr_s;
  logic                 overrun_s;
  logic                 frame_err_r;
  logic                 overrun_err_r;
  logic                 busy_r;
  logic                 fifo_full_s;
  logic                 fifo_empty_s;
  logic [7:0]           fifo_data_s;
  logic                 pop_s;

  // Two-flop synchroniser for the asynchronous pin; resets to the idle level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= 1'b1;
      rxs_r   <= 1'b1;
    end else begin
      sync1_r <= uart_rxp;
      rxs_r   <= sync1_r;
    end
  end

  // Next-state logic: bit timing, start validation, shifting and stop check.
  always_comb begin
    state_s   = state_r;
    timer_s   = timer_r + TW'(1);
    bit_idx_s = bit_idx_r;
    shift_s   = shift_r;
    push_s    = 1'b0;
    ferr_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        timer_s = {TW{1'b0}};
        if (!rxs_r) begin
          state_s = ST_START;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_START: begin
        // Mid-start-bit check rejects short low glitches.
        if (timer_r == HALF_M1) begin
          timer_s = {TW{1'b0}};
          if (rxs_r) begin
            state_s = ST_IDLE;
          end else begin
            state_s   = ST_DATA;
            bit_idx_s = 3'd0;
          end
        end else begin
          state_s = ST_START;
        end
      end
      ST_DATA: begin
        if (timer_r == CPB_M1) begin
          timer_s = {TW{1'b0}};
          shift_s = {rxs_r, shift_r[7:1]};
          if (bit_idx_r == LAST_BIT) begin
            state_s = ST_STOP;
          end else begin
            bit_idx_s = bit_idx_r + 3'd1;
          end
        end else begin
          state_s = ST_DATA;
        end
      end
      ST_STOP: begin
        if (timer_r == CPB_M1) begin
          timer_s = {TW{1'b0}};
          if (rxs_r) begin
            push_s  = 1'b1;
            state_s = ST_IDLE;
          end else begin
            ferr_s  = 1'b1;
            state_s = ST_WAIT_HIGH;
          end
        end else begin
          state_s = ST_STOP;
        end
      end
      ST_WAIT_HIGH: begin
        // Hold off until the line returns high so a break reports once.
        timer_s = {TW{1'b0}};
        if (rxs_r) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_WAIT_HIGH;
        end
      end
      default: begin
        state_s = ST_IDLE;
        timer_s = {TW{1'b0}};
      end
    endcase
  end

  // A pop in the same cycle makes room, so only a push without pop overruns.
  assign pop_s     = !fifo_empty_s && rx_ready;
  assign overrun_s = push_s && fifo_full_s && !pop_s;

  // FSM, datapath and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= ST_IDLE;
      timer_r       <= {TW{1'b0}};
      bit_idx_r     <= 3'd0;
      shift_r       <= 8'h00;
      frame_err_r   <= 1'b0;
      overrun_err_r <= 1'b0;
      busy_r        <= 1'b0;
    end else begin
      state_r       <= state_s;
      timer_r       <= timer_s;
      bit_idx_r     <= bit_idx_s;
      shift_r       <= shift_s;
      frame_err_r   <= ferr_s;
      overrun_err_r <= overrun_s;
      busy_r        <= (state_s != ST_IDLE);
    end
  end

  sync_fifo #(
    .width (8),
    .depth (fifo_depth)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (push_s),
    .wr_data (shift_r),
    .rd_en   (rx_ready),
    .rd_data (fifo_data_s),
    .full    (fifo_full_s),
    .empty   (fifo_empty_s)
  );

  assign rx_data     = fifo_data_s;
  assign rx_valid    = !fifo_empty_s;
  assign frame_err   = frame_err_r;
  assign overrun_err = overrun_err_r;
  assign rx_busy     = busy_r;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed self-checking bench for uart_rx at default parameters.
module tb_uart_rx;

  localparam int CPB = 234;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       uart_rxp = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun_err;
  logic       rx_busy;

  int checks = 0;
  int failures = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  logic [7:0] rx_q[$];

  logic valid_pre, valid_post, busy_post, fe_post, ov_post;

  always #5 clk = ~clk;

  uart_rx dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .uart_rxp    (uart_rxp),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .frame_err   (frame_err),
    .overrun_err (overrun_err),
    .rx_busy     (rx_busy)
  );

  // Monitor: record accepted bytes and count error pulse cycles.
  always @(negedge clk) begin
    if (rx_valid && rx_ready) rx_q.push_back(rx_data);
    if (frame_err) fe_cnt++;
    if (overrun_err) ov_cnt++;
  end

  // Advance n rising edges, leaving time 1 unit after the last one.
  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive one frame; stop sample lands 120 edges into the stop bit.
  task automatic send_byte(input logic [7:0] b, input logic stop_val, input bit pop_at_stop);
    logic saved;
    uart_rxp = 1'b0;
    wait_clks(CPB);
    for (int i = 0; i < 8; i++) begin
      uart_rxp = b[i];
      wait_clks(CPB);
    end
    uart_rxp = stop_val;
    wait_clks(119);
    valid_pre = rx_valid;
    saved = rx_ready;
    if (pop_at_stop) rx_ready = 1'b1;
    wait_clks(1);
    valid_post = rx_valid;
    busy_post  = rx_busy;
    fe_post    = frame_err;
    ov_post    = overrun_err;
    rx_ready   = saved;
    wait_clks(CPB - 120);
  endtask

  task automatic test_reset;
    wait_clks(3);
    checks++;
    if ({rx_valid, rx_busy, frame_err, overrun_err, rx_data} !== 12'h000) begin
      failures++;
      $display("FAIL reset_outputs: got %h expected 000", {rx_valid, rx_busy, frame_err, overrun_err, rx_data});
    end
    rst_n = 1'b1;
    wait_clks(CPB);
    checks++;
    if ({rx_valid, rx_busy, frame_err, overrun_err, rx_data} !== 12'h000) begin
      failures++;
      $display("FAIL post_reset_idle: got %h expected 000", {rx_valid, rx_busy, frame_err, overrun_err, rx_data});
    end
  endtask

  task automatic test_basic;
    int fe0, ov0;
    fe0 = fe_cnt; ov0 = ov_cnt;
    rx_q.delete();
    rx_ready = 1'b1;
    send_byte(8'h55, 1'b1, 1'b0);
    checks++;
    if (valid_pre !== 1'b0 || valid_post !== 1'b1) begin
      failures++;
      $display("FAIL push_latency: pre=%b post=%b expected pre=0 post=1", valid_pre, valid_post);
    end
    checks++;
    if (busy_post !== 1'b0) begin
      failures++;
      $display("FAIL busy_after_stop_55: got %b expected 0", busy_post);
    end
    send_byte(8'hA3, 1'b1, 1'b0);
    checks++;
    if (busy_post !== 1'b0) begin
      failures++;
      $display("FAIL busy_after_stop_a3: got %b expected 0", busy_post);
    end
    checks++;
    if (rx_q.size() != 2) begin
      failures++;
      $display("FAIL basic_count: got %0d expected 2", rx_q.size());
    end else begin
      checks++;
      if (rx_q[0] !== 8'h55 || rx_q[1] !== 8'hA3) begin
        failures++;
        $display("FAIL basic_data: got %h %h expected 55 a3", rx_q[0], rx_q[1]);
      end
    end
    checks++;
    if (fe_cnt - fe0 != 0 || ov_cnt - ov0 != 0) begin
      failures++;
      $display("FAIL basic_errors: got fe=%0d ov=%0d expected 0 0", fe_cnt - fe0, ov_cnt - ov0);
    end
  endtask

  task automatic test_glitch;
    int fe0;
    fe0 = fe_cnt;
    rx_q.delete();
    uart_rxp = 1'b0;
    wait_clks(50);
    uart_rxp = 1'b1;
    checks++;
    if (rx_busy !== 1'b1) begin
      failures++;
      $display("FAIL glitch_busy_start: got %b expected 1", rx_busy);
    end
    wait_clks(80);
    checks++;
    if (rx_busy !== 1'b0 || rx_valid !== 1'b0) begin
      failures++;
      $display("FAIL glitch_idle: got busy=%b valid=%b expected 0 0", rx_busy, rx_valid);
    end
    checks++;
    if (fe_cnt - fe0 != 0 || rx_q.size() != 0) begin
      failures++;
      $display("FAIL glitch_no_effect: got fe=%0d bytes=%0d expected 0 0", fe_cnt - fe0, rx_q.size());
    end
    wait_clks(CPB);
  endtask

  task automatic test_frame_error;
    int fe0;
    fe0 = fe_cnt;
    rx_q.delete();
    rx_ready = 1'b1;
    send_byte(8'h3C, 1'b0, 1'b0);
    checks++;
    if (fe_post !== 1'b1) begin
      failures++;
      $display("FAIL frame_err_timing: got %b expected 1", fe_post);
    end
    wait_clks(2 * CPB);
    checks++;
    if (rx_busy !== 1'b1) begin
      failures++;
      $display("FAIL wait_high_busy: got %b expected 1", rx_busy);
    end
    uart_rxp = 1'b1;
    wait_clks(CPB);
    checks++;
    if (rx_busy !== 1'b0 || fe_cnt - fe0 != 1 || rx_q.size() != 0) begin
      failures++;
      $display("FAIL break_once: got busy=%b fe=%0d bytes=%0d expected 0 1 0", rx_busy, fe_cnt - fe0, rx_q.size());
    end
    send_byte(8'h7E, 1'b1, 1'b0);
    checks++;
    if (rx_q.size() != 1) begin
      failures++;
      $display("FAIL after_break_count: got %0d expected 1", rx_q.size());
    end else begin
      checks++;
      if (rx_q[0] !== 8'h7E) begin
        failures++;
        $display("FAIL after_break_data: got %h expected 7e", rx_q[0]);
      end
    end
    checks++;
    if (fe_cnt - fe0 != 1) begin
      failures++;
      $display("FAIL after_break_fe: got %0d expected 1", fe_cnt - fe0);
    end
  endtask

  task automatic test_overrun;
    int ov0;
    logic [7:0] exp;
    ov0 = ov_cnt;
    rx_q.delete();
    rx_ready = 1'b0;
    for (int i = 0; i < 17; i++) send_byte(8'(i), 1'b1, 1'b0);
    checks++;
    if (ov_cnt - ov0 != 1) begin
      failures++;
      $display("FAIL overrun_count: got %0d expected 1", ov_cnt - ov0);
    end
    checks++;
    if (rx_valid !== 1'b1 || rx_data !== 8'h00) begin
      failures++;
      $display("FAIL full_head: got valid=%b data=%h expected 1 00", rx_valid, rx_data);
    end
    // Full FIFO with a pop on the stop-sample cycle: push must be accepted.
    send_byte(8'h11, 1'b1, 1'b1);
    checks++;
    if (ov_post !== 1'b0 || ov_cnt - ov0 != 1) begin
      failures++;
      $display("FAIL full_pop_no_overrun: got pulse=%b total=%0d expected 0 1", ov_post, ov_cnt - ov0);
    end
    rx_ready = 1'b1;
    for (int i = 0; i < 40 && rx_valid; i++) wait_clks(1);
    rx_ready = 1'b0;
    checks++;
    if (rx_valid !== 1'b0) begin
      failures++;
      $display("FAIL drain_empty: got %b expected 0", rx_valid);
    end
    checks++;
    if (rx_q.size() != 17) begin
      failures++;
      $display("FAIL drain_count: got %0d expected 17", rx_q.size());
    end else begin
      for (int i = 0; i < 17; i++) begin
        exp = (i < 16) ? 8'(i) : 8'h11;
        checks++;
        if (rx_q[i] !== exp) begin
          failures++;
          $display("FAIL drain_data[%0d]: got %h expected %h", i, rx_q[i], exp);
        end
      end
    end
  endtask

  task automatic test_reset_mid_frame;
    int fe0, ov0;
    logic [7:0] b;
    rx_q.delete();
    rx_ready = 1'b0;
    send_byte(8'h9A, 1'b1, 1'b0);
    checks++;
    if (rx_valid !== 1'b1 || rx_data !== 8'h9A) begin
      failures++;
      $display("FAIL preload: got valid=%b data=%h expected 1 9a", rx_valid, rx_data);
    end
    b = 8'h3F;
    uart_rxp = 1'b0;
    wait_clks(CPB);
    for (int i = 0; i < 4; i++) begin
      uart_rxp = b[i];
      wait_clks(CPB);
    end
    uart_rxp = b[4];
    wait_clks(100);
    checks++;
    if (rx_busy !== 1'b1) begin
      failures++;
      $display("FAIL busy_mid_frame: got %b expected 1", rx_busy);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({rx_valid, rx_busy, frame_err, overrun_err, rx_data} !== 12'h000) begin
      failures++;
      $display("FAIL async_reset_outputs: got %h expected 000", {rx_valid, rx_busy, frame_err, overrun_err, rx_data});
    end
    uart_rxp = 1'b1;
    wait_clks(5);
    rst_n = 1'b1;
    wait_clks(CPB);
    fe0 = fe_cnt; ov0 = ov_cnt;
    rx_ready = 1'b1;
    send_byte(8'hC5, 1'b1, 1'b0);
    wait_clks(2);
    checks++;
    if (rx_q.size() != 1) begin
      failures++;
      $display("FAIL post_reset_count: got %0d expected 1", rx_q.size());
    end else begin
      checks++;
      if (rx_q[0] !== 8'hC5) begin
        failures++;
        $display("FAIL post_reset_data: got %h expected c5", rx_q[0]);
      end
    end
    checks++;
    if (fe_cnt - fe0 != 0 || ov_cnt - ov0 != 0) begin
      failures++;
      $display("FAIL post_reset_errors: got fe=%0d ov=%0d expected 0 0", fe_cnt - fe0, ov_cnt - ov0);
    end
  endtask

  // Hard time limit so the run always terminates.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_frame_error();
    test_overrun();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

UART receiver for the board test design. It is the receive-side counterpart of the existing `uart_txp` transmit path. It deserialises 8N1 frames from the host-facing RX pin, validates start and stop bits, and buffers received bytes in a small FIFO. Bytes are presented on a valid/ready stream so the DDR3 test logic or key/LED test logic can accept host commands.

## Interface
- `frequency`, 27_000_000: clock frequency in Hz.
- `baud_rate`, 115_200: line rate in bit/s.
- `fifo_depth`, 16: receive FIFO entries; must be a power of two, at least 2.
- `clk`, in, 1: system clock, 27 MHz oscillator.
- `rst_n`, in, 1: reset, asynchronous, active-low. One clock; reset is asynchronous and active-low.
- `uart_rxp`, in, 1: serial input. Asynchronous to `clk`; idles high.
- `rx_data`, out, 8: byte at the FIFO head.
- `rx_valid`, out, 1: FIFO not empty.
- `rx_ready`, in, 1: consumer accepts `rx_data` this cycle.
- `frame_err`, out, 1: one-cycle pulse when a stop bit is sampled low.
- `overrun_err`, out, 1: one-cycle pulse when a good byte is dropped because the FIFO is full.
- `rx_busy`, out, 1: high while the FSM is not in IDLE.

## Operation
- **Derived constants**
  - `CPB = frequency/baud_rate`, integer division; the default gives 234.
  - `HALF = CPB/2`; the default gives 117.
  - Bit counter width is `$clog2(CPB)`.
- **Input synchroniser:** `uart_rxp` passes through 2 flops, both reset to 1. Only the synchronised signal `rxs` is used.
- **FSM states:** IDLE, START, DATA, STOP, WAIT_HIGH.
  - IDLE: when `rxs`=0, go to START and clear the bit-timer.
  - START: when the timer reaches `HALF-1`, sample `rxs`.
    - 1: glitch; return to IDLE with no error.
    - 0: go to DATA, clear the timer and the bit index.
  - DATA: when the timer reaches `CPB-1`, sample `rxs` into the shift register, LSB first, and clear the timer. After the 8th sample, go to STOP.
  - STOP: when the timer reaches `CPB-1`, sample `rxs`.
    - 1: push the byte and go to IDLE.
    - 0: pulse `frame_err`, discard the byte, go to WAIT_HIGH.
  - WAIT_HIGH: stay until `rxs`=1, then go to IDLE. A break condition therefore produces exactly one `frame_err`.
- **FIFO behaviour**
  - Show-ahead: `rx_data` is always the head entry; `rx_valid = !empty`.
  - Pop when `rx_valid && rx_ready`.
  - Pointers are `$clog2(fifo_depth)+1` bits wide and wrap naturally.
- **Boundary conditions**
  - Push while full with no pop: the byte is dropped, `overrun_err` pulses, and the FIFO contents are unchanged.
  - Push while full with a pop in the same cycle: the push is accepted and the count stays at `fifo_depth`.
  - Push while empty: no bypass; `rx_valid` rises the next cycle.
  - `rx_ready` while empty: ignored.
- **Reset**, asserted at any time including mid-frame:
  - FSM goes to IDLE, FIFO is emptied, synchroniser is set to 1.
  - All outputs go to 0, including `rx_data`=0x00.
  - Reception restarts on the next falling edge after release.

## Timing
- Let cycle 0 be the first cycle with `rxs`=0 in IDLE. Sample points:
  - Start bit: cycle `HALF`.
  - Data bit n (n = 0..7): cycle `HALF + (n+1)*CPB`.
  - Stop bit: cycle `HALF + 9*CPB`.
- Pin-to-`rxs` latency is 2 cycles.
- Byte delivery: the FIFO write occurs on the stop-sample edge, and `rx_valid`/`rx_data` update 1 cycle later.
- `frame_err` and `overrun_err` are registered and high for exactly the cycle after the stop sample.
- Back-to-back frames:
  - A new start bit is detected from the first IDLE cycle, half a bit after the stop sample.
  - Baud error tolerance is ±4% at the default parameters.
- Pop: the head advances on the `rx_valid && rx_ready` edge, and the new head is visible the next cycle.

## Structure
- **Package `uart_pkg`:**
  - FSM state enum `uart_rx_state_t`.
  - Function `calc_cpb(frequency, baud_rate)`.
  - Localparams for data bits (8) and stop bits (1).
  - Shared with the transmit side.
- **Sub-module `sync_fifo`:**
  - Parameterised width and depth, show-ahead, with full/empty flags.
  - `uart_rx` instantiates it with width 8 and depth `fifo_depth`.
- **In `uart_rx` itself:** synchroniser, FSM, bit-timer and shift register.

## Test plan
- Send 0x55 then 0xA3 at 115200 with `rx_ready`=1 → two `rx_valid` beats carrying 0x55 then 0xA3, no error pulses, `rx_busy` low after each stop sample.
- Drive a 50-cycle low glitch on `uart_rxp` → no `rx_valid`, no `frame_err`, FSM back in IDLE by cycle ~120.
- Send 0x3C with the stop bit driven low and the line held low for 3 bit times → exactly one `frame_err` pulse, no byte stored. A following valid 0x7E is received correctly.
- With `rx_ready`=0, send 17 bytes 0x00..0x10 → 16 stored, one `overrun_err` on the 17th. Draining yields 0x00..0x0F in order, then `rx_valid`=0.
- FIFO full with `rx_ready`=1 in the cycle of the stop sample → no overrun, count stays at 16, and the new byte appears last when drained.
- Assert `rst_n` low during bit 4 of a frame → all outputs 0 immediately. After release, the next frame 0xC5 is received intact with no error.
